serial_word_tx: RTL and testbench
=================================

# serial_word_tx

Parameterized parallel-to-serial transmitter. It accepts SIZE-bit words through a load/ready handshake and drives them LSB-first onto a one-bit serial line, one bit per clock. It is the source side of the serial-input sequence detectors (mealy/moore), replacing bench-side bit shifting with synthesizable logic. A one-word holding register allows back-to-back frames with no idle cycle.

## Interface
- SIZE, 24: word width in bits; legal range is SIZE >= 2.
- GAP, 0: idle cycles inserted between consecutive words; legal range is 0..255.

- clock  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data  input  SIZE  word to transmit; sampled only on an accepting edge.
- load  input  1  load request; the word is accepted on an edge where load && ready.
- ready  output  1  holding register is empty, so a new word can be accepted.
- out  output  1  serial data bit, LSB first.
- valid  output  1  out carries a data bit this cycle.
- last  output  1  out carries bit SIZE-1 of the current word.
- done  output  1  one-cycle pulse in the cycle after a word's last bit.

## Operation
- All outputs are registered.
- Internal state:
  - shift register, SIZE bits;
  - bit counter, $clog2(SIZE) bits, counting 0..SIZE-1;
  - gap counter, 8 bits;
  - holding register plus a hold_full flag.
- States:
  - IDLE: valid=0, out=0.
  - SHIFT: valid=1, out=shift[0], advancing one bit per edge.
  - GAP: valid=0, out=0, for GAP cycles.
- ready = !hold_full.
- Accept in IDLE (hold empty): the word loads straight into the shift register and the state becomes SHIFT. The holding register stays empty and ready stays 1.
- Accept in SHIFT or GAP: the word goes to the holding register, hold_full sets, and ready drops on the same edge.
- Word end is the edge at which bit counter == SIZE-1 in SHIFT:
  - done=1 for the following cycle.
  - If GAP>0: enter GAP and clear the gap counter.
  - If GAP==0: next-word selection applies immediately.
- Next-word selection, at word end (GAP==0) or at GAP expiry, in priority order:
  1. hold_full: move hold to the shift register, clear hold_full (ready rises), enter SHIFT.
  2. Otherwise load && ready: take data directly into the shift register, enter SHIFT.
  3. Otherwise: go to IDLE.
- load while ready=0 is ignored. The data is dropped, and no error is flagged.
- last = valid && (bit counter == SIZE-1).
- Reset (rst high at an edge):
  - state IDLE; out=0, valid=0, last=0, done=0, ready=1;
  - hold_full=0, all counters 0;
  - load is ignored on that edge.
  - Reset mid-word aborts transmission with no done pulse and discards any held word.

## Timing
- Latency: load is accepted at edge k (idle, hold empty). Bit 0 is on out with valid=1 in the cycle after edge k. Bit i appears after edge k+i.
- Each word produces exactly SIZE consecutive valid cycles. last is high only in the SIZE-th.
- done is high in the cycle after last. With GAP==0 and a queued word, that same cycle carries the next word's bit 0 with valid=1.
- GAP>0: exactly GAP cycles of valid=0 between last and the next bit 0.
- ready returns to 1 in the cycle the held word's bit 0 is driven.
- Throughput: 100% line utilization when GAP==0 and the holding register is refilled each word.

## Test plan
- Reset: hold rst=1 for 2 cycles with load=1 → out=0, valid=0, last=0, done=0, ready=1 throughout, and no word is accepted.
- Single word: SIZE=24, data=24'hCD4D54, one-cycle load while idle.
  - out over 24 valid cycles = 0,0,1,0,1,0,1,0, 1,0,1,1,0,0,1,0, 1,0,1,1,0,0,1,1.
  - last on the 24th cycle, done in the 25th, then valid=0.
  - When chained into the mealy/moore detectors, the flags must match the bench-driven run.
- Back-to-back, GAP=0: load 24'h000001, then 24'h800000 during bit 3.
  - ready=0 from the second accept until the first word's done cycle.
  - 48 contiguous valid cycles: out=1 on cycle 1 and cycle 48, 0 elsewhere; last on cycles 24 and 48.
- Gap insertion, GAP=3, same two words: valid=0 and out=0 for exactly 3 cycles between the first last and the second word's bit 0.
- Reset mid-word: assert rst for one edge while bit 10 is on out with a word held → the next cycle shows reset values, no done pulse, ready=1, and the held word is never transmitted.
- Dropped load: with hold full (ready=0), pulse load with 24'hFFFFFF → it is never transmitted, and the held word follows unchanged.

Source files
------------

// File: rtl/serial_word_tx_if.sv
// Word-in / bit-out port bundle for serial_word_tx.
// The master side supplies words; the slave side (the transmitter) drives the serial line.
`timescale 1ns/1ps
interface serial_word_tx_if #(
  parameter int SIZE = 24
);
  logic [SIZE-1:0] data;
  logic            load;
  logic            ready;
  logic            out;
  logic            valid;
  logic            last;
  logic            done;

  modport master (
    output data, load,
    input  ready, out, valid, last, done
  );

  modport slave (
    input  data, load,
    output ready, out, valid, last, done
  );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: SIZE-bit words go out LSB first, one bit per clock.
// A one-word holding register lets the next word follow with no idle cycle.
`timescale 1ns/1ps
module serial_word_tx #(
  parameter int SIZE = 24,
  parameter int GAP  = 0
) (
  input logic             clock,
  input logic             rst,
  serial_word_tx_if.slave bus
);
  localparam int                CNT_W    = $clog2(SIZE);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SIZE - 1);
  localparam logic [7:0]        GAP_END  = 8'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [SIZE-1:0]  shift_q, shift_d;
  logic [SIZE-1:0]  hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             accept;
  logic             select_next;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    select_next = 1'b0;
    accept      = bus.load && !hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d   = bus.data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          done_d = 1'b1;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            select_next = 1'b1;
          end
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_END) select_next = 1'b1;
        else                      gap_cnt_d   = gap_cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A held word outranks a fresh load; a fresh load at a word boundary bypasses the hold.
    if (select_next) begin
      bit_cnt_d = '0;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
        state_d     = ST_SHIFT;
      end else if (accept) begin
        shift_d = bus.data;
        state_d = ST_SHIFT;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (accept && state_q != ST_IDLE) begin
      hold_d      = bus.data;
      hold_full_d = 1'b1;
    end

    valid_d = (state_d == ST_SHIFT);
    out_d   = valid_d && shift_d[0];
    last_d  = valid_d && (bit_cnt_d == LAST_BIT);
  end

  // NOTE: synchronous reset inside the clocked block; state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  // NOTE: word registers need no reset; they are only read while state/hold_full mark them live.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  assign bus.ready = !hold_full_q;
  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: a per-cycle vector table plus hand-written multi-cycle sequences.
// Two instances (GAP=0 and GAP=3) receive identical stimulus.
`timescale 1ns/1ps
module tb_serial_word_tx;
  localparam int SIZE = 24;

  typedef struct {
    logic            rst;
    logic            load;
    logic [SIZE-1:0] data;
    logic            e_out;
    logic            e_valid;
    logic            e_last;
    logic            e_done;
    logic            e_ready;
  } vec_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_word_tx_if #(.SIZE(SIZE)) if0 ();
  serial_word_tx_if #(.SIZE(SIZE)) if3 ();

  serial_word_tx #(.SIZE(SIZE), .GAP(0)) u_dut0 (.clock(clock), .rst(rst), .bus(if0.slave));
  serial_word_tx #(.SIZE(SIZE), .GAP(3)) u_dut3 (.clock(clock), .rst(rst), .bus(if3.slave));

  always #5 clock = ~clock;

  vec_t vecs [29];
  bit   cd_bits [24] = '{0,0,1,0,1,0,1,0, 1,0,1,1,0,0,1,0, 1,0,1,1,0,0,1,1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [SIZE-1:0] d);
    if0.load = l;
    if0.data = d;
    if3.load = l;
    if3.data = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_both(input string tag, input logic o0, v0, l0, d0, r0,
                            input logic o3, v3, l3, d3, r3);
    check({tag, " dut0 out"},   if0.out,   o0);
    check({tag, " dut0 valid"}, if0.valid, v0);
    check({tag, " dut0 last"},  if0.last,  l0);
    check({tag, " dut0 done"},  if0.done,  d0);
    check({tag, " dut0 ready"}, if0.ready, r0);
    check({tag, " dut3 out"},   if3.out,   o3);
    check({tag, " dut3 valid"}, if3.valid, v3);
    check({tag, " dut3 last"},  if3.last,  l3);
    check({tag, " dut3 done"},  if3.done,  d3);
    check({tag, " dut3 ready"}, if3.ready, r3);
  endtask

  function automatic vec_t mk(bit r, bit l, logic [SIZE-1:0] d, bit o, bit v, bit la, bit dn, bit rd);
    vec_t t;
    t.rst = r; t.load = l; t.data = d;
    t.e_out = o; t.e_valid = v; t.e_last = la; t.e_done = dn; t.e_ready = rd;
    return t;
  endfunction

  initial begin
    drive(1'b1, 24'hFFFFFF);

    // Reset with load held high, then a single CD4D54 word from idle.
    vecs[0] = mk(1, 1, 24'hFFFFFF, 0, 0, 0, 0, 1);
    vecs[1] = mk(1, 1, 24'hFFFFFF, 0, 0, 0, 0, 1);
    vecs[2] = mk(0, 0, 24'h000000, 0, 0, 0, 0, 1);
    vecs[3] = mk(0, 1, 24'hCD4D54, cd_bits[0], 1, 0, 0, 1);
    for (int j = 1; j < 24; j++)
      vecs[3 + j] = mk(0, 0, 24'h000000, cd_bits[j], 1, (j == 23), 0, 1);
    vecs[27] = mk(0, 0, 24'h000000, 0, 0, 0, 1, 1);
    vecs[28] = mk(0, 0, 24'h000000, 0, 0, 0, 0, 1);

    for (int i = 0; i < 29; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].load, vecs[i].data);
      step();
      check_both($sformatf("vec%0d", i),
                 vecs[i].e_out, vecs[i].e_valid, vecs[i].e_last, vecs[i].e_done, vecs[i].e_ready,
                 vecs[i].e_out, vecs[i].e_valid, vecs[i].e_last, vecs[i].e_done, vecs[i].e_ready);
    end
    idle(2);

    // Back-to-back: 000001 then 800000 loaded during bit 3; c counts cycles after the first accept.
    drive(1'b1, 24'h000001);
    step();
    for (int c = 1; c <= 55; c++) begin
      check_both($sformatf("b2b c%0d", c),
                 (c == 1 || c == 48), (c <= 48), (c == 24 || c == 48), (c == 25 || c == 49),
                 !(c >= 5 && c <= 24),
                 (c == 1 || c == 51), (c <= 24 || (c >= 28 && c <= 51)), (c == 24 || c == 51),
                 (c == 25 || c == 52), !(c >= 5 && c <= 27));
      drive(c == 4, 24'h800000);
      step();
    end
    idle(2);

    // Reset mid-word: rst for one edge while bit 10 of 000400 is on out and 5A5A5A is held.
    drive(1'b1, 24'h000400);
    step();
    for (int c = 1; c <= 10; c++) begin
      drive(c == 4, 24'h5A5A5A);
      step();
    end
    check_both("pre-reset", 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    rst = 1'b1;
    drive(1'b0, '0);
    step();
    rst = 1'b0;
    check_both("post-reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    begin
      int v0 = 0, v3 = 0, d0 = 0, d3 = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        v0 += int'(if0.valid); v3 += int'(if3.valid);
        d0 += int'(if0.done);  d3 += int'(if3.done);
      end
      check("reset dut0 valid count", v0, 0);
      check("reset dut3 valid count", v3, 0);
      check("reset dut0 done count",  d0, 0);
      check("reset dut3 done count",  d3, 0);
    end

    // Dropped load: FFFFFF pulsed while hold is full must never appear on the line.
    begin
      logic [SIZE-1:0] rx0 [2];
      logic [SIZE-1:0] rx3 [2];
      int n0 = 0, n3 = 0;
      rx0[0] = '0; rx0[1] = '0; rx3[0] = '0; rx3[1] = '0;
      drive(1'b1, 24'h0F0F0F);
      step();
      for (int c = 1; c <= 60; c++) begin
        if (if0.valid === 1'b1) begin
          if (n0 < 48) rx0[n0 / 24][n0 % 24] = if0.out;
          n0++;
        end
        if (if3.valid === 1'b1) begin
          if (n3 < 48) rx3[n3 / 24][n3 % 24] = if3.out;
          n3++;
        end
        if (c == 6) begin
          check("drop dut0 ready", if0.ready, 0);
          check("drop dut3 ready", if3.ready, 0);
        end
        if (c == 3)      drive(1'b1, 24'h123456);
        else if (c == 6) drive(1'b1, 24'hFFFFFF);
        else             drive(1'b0, '0);
        step();
      end
      check("drop dut0 bit count", n0, 48);
      check("drop dut3 bit count", n3, 48);
      check("drop dut0 word0", rx0[0], 24'h0F0F0F);
      check("drop dut0 word1", rx0[1], 24'h123456);
      check("drop dut3 word0", rx3[0], 24'h0F0F0F);
      check("drop dut3 word1", rx3[1], 24'h123456);
      check("drop dut0 final ready", if0.ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
